shuffle_pack_stream: RTL and testbench

Streaming packer directly downstream of the combinational element shuffle. Each shuffle output word carries `IN_ELEMS` selected elements of `A_WIDTH` bits. This block accumulates `BEATS` such words, LSB-first, into one wide AXI-Stream word for the next compute stage. An input `tlast` flushes a partial word, zero-padded, with an element count.

---
 rtl/shuffle_pkg.sv | 15 +
 rtl/axis_out_reg.sv | 58 +++++
 rtl/shuffle_pack_stream.sv | 99 +++++++++
 tb/tb_shuffle_pack_stream.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shuffle_pkg.sv
// Shared helpers for the shuffle stage and its downstream packer.
// Both stages use elem_lsb so they agree that element 0 sits in the LSBs.
package shuffle_pkg;

   // Width of a counter that must hold every value from 0 to max_count.
   function automatic int cnt_width(input int max_count);
      return $clog2(max_count + 1);
   endfunction

   // Bit offset of element elem_idx inside a word of a_width-bit elements.
   function automatic int elem_lsb(input int elem_idx, input int a_width);
      return elem_idx * a_width;
   endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Registered AXI-Stream output stage: holds a tdata/tlast/tuser payload and
// its valid flag. A new payload can be taken whenever the register is empty
// or is being drained in the same cycle, so it never inserts a bubble.
module axis_out_reg #(
   parameter int DATA_W = 8,
   parameter int USER_W = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] data_in,
   input  logic              last_in,
   input  logic [USER_W-1:0] user_in,
   output logic              ready_out,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic              last,
   output logic [USER_W-1:0] user,
   input  logic              ready_in
);

   logic              valid_r;
   logic [DATA_W-1:0] data_r;
   logic              last_r;
   logic [USER_W-1:0] user_r;
   logic              ready_s;

   // Upstream may push whenever the slot is free or emptying this cycle.
   always_comb begin
      ready_s = !valid_r || ready_in;
   end

   // Payload and valid register; payload only moves when a new word loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         data_r  <= '0;
         last_r  <= 1'b0;
         user_r  <= '0;
      end else if (load && ready_s) begin
         valid_r <= 1'b1;
         data_r  <= data_in;
         last_r  <= last_in;
         user_r  <= user_in;
      end else if (ready_in) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign ready_out = ready_s;
   assign valid     = valid_r;
   assign data      = data_r;
   assign last      = last_r;
   assign user      = user_r;

endmodule

// File: rtl/shuffle_pack_stream.sv
// Packs BEATS shuffle output words (IN_ELEMS elements each) LSB-first into one
// wide AXI-Stream word. tlast flushes a partial, zero-padded word and tuser
// reports how many elements of the word are valid.
module shuffle_pack_stream
   import shuffle_pkg::*;
#(
   parameter  int A_WIDTH   = 2,
   parameter  int IN_ELEMS  = 3,
   parameter  int BEATS     = 4,
   localparam int IN_W      = IN_ELEMS * A_WIDTH,
   localparam int OUT_ELEMS = IN_ELEMS * BEATS,
   localparam int OUT_W     = OUT_ELEMS * A_WIDTH,
   localparam int CNT_W     = cnt_width(OUT_ELEMS)
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic [IN_W-1:0]  s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   input  logic             s_axis_tlast,
   output logic [OUT_W-1:0] m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tlast,
   output logic [CNT_W-1:0] m_axis_tuser
);

   // A 1-bit counter is kept even for BEATS=1; it then never leaves 0.
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [BEAT_W-1:0] cnt_r;
   logic [OUT_W-1:0]  asm_r;
   logic [OUT_W-1:0]  merged_s;
   logic [CNT_W-1:0]  fill_s;
   logic              ready_s;
   logic              accept_s;
   logic              last_slot_s;
   logic              complete_s;

   // Completion decode: a beat completes the word on the last slot or on tlast.
   always_comb begin
      accept_s    = s_axis_tvalid && ready_s;
      last_slot_s = (cnt_r == BEAT_W'(BEATS - 1));
      complete_s  = accept_s && (last_slot_s || s_axis_tlast);
      fill_s      = CNT_W'((int'(cnt_r) + 1) * IN_ELEMS);
   end

   // Assembly word with the current slot replaced by the incoming beat.
   always_comb begin
      merged_s = asm_r;
      for (int b = 0; b < BEATS; b++) begin
         if (b == int'(cnt_r)) begin
            merged_s[elem_lsb(b * IN_ELEMS, A_WIDTH) +: IN_W] = s_axis_tdata;
         end else begin
            merged_s[elem_lsb(b * IN_ELEMS, A_WIDTH) +: IN_W] =
               asm_r[elem_lsb(b * IN_ELEMS, A_WIDTH) +: IN_W];
         end
      end
   end

   // Assembly register and beat counter; cleared on every emit so flushed
   // words carry zeros above the last filled slot.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         asm_r <= '0;
         cnt_r <= '0;
      end else if (complete_s) begin
         asm_r <= '0;
         cnt_r <= '0;
      end else if (accept_s) begin
         asm_r <= merged_s;
         cnt_r <= cnt_r + BEAT_W'(1);
      end else begin
         asm_r <= asm_r;
         cnt_r <= cnt_r;
      end
   end

   axis_out_reg #(
      .DATA_W (OUT_W),
      .USER_W (CNT_W)
   ) u_out (
      .clk       (ap_clk),
      .rst       (ap_rst),
      .load      (complete_s),
      .data_in   (merged_s),
      .last_in   (s_axis_tlast),
      .user_in   (fill_s),
      .ready_out (ready_s),
      .valid     (m_axis_tvalid),
      .data      (m_axis_tdata),
      .last      (m_axis_tlast),
      .user      (m_axis_tuser),
      .ready_in  (m_axis_tready)
   );

   assign s_axis_tready = ready_s;

endmodule

// File: tb/tb_shuffle_pack_stream.sv
// Self-checking bench for shuffle_pack_stream: a BEATS=4 instance with
// directed and random traffic, and a BEATS=1 instance with random traffic.
module tb_shuffle_pack_stream;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // BEATS=4 instance
   logic [5:0]  s_tdata;
   logic        s_tvalid, s_tready, s_tlast;
   logic [23:0] m_tdata;
   logic        m_tvalid, m_tready, m_tlast;
   logic [3:0]  m_tuser;

   // BEATS=1 instance
   logic [5:0]  s1_tdata;
   logic        s1_tvalid, s1_tready, s1_tlast;
   logic [5:0]  m1_tdata;
   logic        m1_tvalid, m1_tready, m1_tlast;
   logic [1:0]  m1_tuser;

   shuffle_pack_stream #(.A_WIDTH(2), .IN_ELEMS(3), .BEATS(4)) u_dut (
      .ap_clk(clk), .ap_rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tlast(s_tlast),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser)
   );

   shuffle_pack_stream #(.A_WIDTH(2), .IN_ELEMS(3), .BEATS(1)) u_dut1 (
      .ap_clk(clk), .ap_rst(rst),
      .s_axis_tdata(s1_tdata), .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
      .s_axis_tlast(s1_tlast),
      .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready),
      .m_axis_tlast(m1_tlast), .m_axis_tuser(m1_tuser)
   );

   typedef struct { logic [23:0] d; logic l; logic [3:0] u; } exp4_t;
   typedef struct { logic [5:0] d; logic l; } exp1_t;

   exp4_t      q4[$];
   exp1_t      q1[$];
   logic [5:0] pend4[$];

   int n_checks = 0;
   int n_pass   = 0;
   int acc4     = 0;
   int words4   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference model: a word is the beats concatenated LSB-first, emitted when
   // four beats are collected or a beat carries tlast.
   task automatic model_accept4(input logic [5:0] d, input logic l);
      exp4_t e;
      pend4.push_back(d);
      if (pend4.size() == 4 || l) begin
         e.d = 24'h0;
         for (int i = 0; i < pend4.size(); i++) e.d = e.d | (24'(pend4[i]) << (6 * i));
         e.l = l;
         e.u = 4'(3 * pend4.size());
         q4.push_back(e);
         pend4.delete();
      end
   endtask

   // One clock: observe handshakes just before the edge, then move past it.
   task automatic step();
      exp4_t e4;
      exp1_t e1;
      @(negedge clk);
      if (rst) begin
         q4.delete();
         q1.delete();
         pend4.delete();
      end else begin
         if (m_tvalid && m_tready) begin
            words4++;
            if (q4.size() == 0) check("dut4_spurious_word", 64'(1), 64'(0));
            else begin
               e4 = q4.pop_front();
               check("dut4_tdata", 64'(m_tdata), 64'(e4.d));
               check("dut4_tuser", 64'(m_tuser), 64'(e4.u));
               check("dut4_tlast", 64'(m_tlast), 64'(e4.l));
            end
         end
         if (s_tvalid && s_tready) begin
            acc4++;
            model_accept4(s_tdata, s_tlast);
         end
         if (m1_tvalid && m1_tready) begin
            if (q1.size() == 0) check("dut1_spurious_word", 64'(1), 64'(0));
            else begin
               e1 = q1.pop_front();
               check("dut1_tdata", 64'(m1_tdata), 64'(e1.d));
               check("dut1_tuser", 64'(m1_tuser), 64'(2'd3));
               check("dut1_tlast", 64'(m1_tlast), 64'(e1.l));
            end
         end
         if (s1_tvalid && s1_tready) begin
            e1.d = s1_tdata;
            e1.l = s1_tlast;
            q1.push_back(e1);
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Present one beat until accepted, with a bounded wait.
   task automatic beat(input logic [5:0] d, input logic l);
      logic done;
      logic rdy;
      done     = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      for (int k = 0; k < 50 && !done; k++) begin
         rdy = s_tready;
         step();
         if (rdy) done = 1'b1;
      end
      if (!done) check("beat_accept_timeout", 64'(0), 64'(1));
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   initial begin
      int a0, w0;
      rst = 1'b1;
      s_tdata = 6'h0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
      s1_tdata = 6'h0; s1_tvalid = 1'b0; s1_tlast = 1'b0; m1_tready = 1'b1;

      // Reset state
      step(); step();
      check("rst_tvalid", 64'(m_tvalid), 64'(0));
      check("rst_tdata",  64'(m_tdata),  64'(0));
      check("rst_tuser",  64'(m_tuser),  64'(0));
      check("rst_tlast",  64'(m_tlast),  64'(0));
      rst = 1'b0;
      step();
      check("ready_after_rst", 64'(s_tready), 64'(1));

      // Test 1: full word
      beat(6'h01, 1'b0); beat(6'h02, 1'b0); beat(6'h03, 1'b0);
      check("t1_no_early_valid", 64'(m_tvalid), 64'(0));
      beat(6'h04, 1'b0);
      check("t1_valid",  64'(m_tvalid), 64'(1));
      check("t1_tdata",  64'(m_tdata),  64'(24'h103081));
      check("t1_tuser",  64'(m_tuser),  64'(12));
      check("t1_tlast",  64'(m_tlast),  64'(0));
      step();

      // Test 2: tlast flush, then a fresh word without residue
      beat(6'h3F, 1'b0); beat(6'h15, 1'b1);
      check("t2_tdata", 64'(m_tdata), 64'(24'h00057F));
      check("t2_tuser", 64'(m_tuser), 64'(6));
      check("t2_tlast", 64'(m_tlast), 64'(1));
      for (int i = 0; i < 4; i++) beat(6'($urandom), 1'b0);
      step();

      // Test 3: back-pressure for 10 cycles
      m_tready = 1'b0;
      for (int i = 0; i < 4; i++) beat(6'($urandom), 1'b0);
      s_tvalid = 1'b1;
      s_tdata  = 6'h2A;
      for (int i = 0; i < 10; i++) begin
         step();
         check("t3_tready_low", 64'(s_tready), 64'(0));
         check("t3_valid_held", 64'(m_tvalid), 64'(1));
         if (q4.size() > 0) begin
            check("t3_tdata_held", 64'(m_tdata), 64'(q4[0].d));
            check("t3_tuser_held", 64'(m_tuser), 64'(q4[0].u));
            check("t3_tlast_held", 64'(m_tlast), 64'(q4[0].l));
         end else begin
            check("t3_word_missing", 64'(0), 64'(1));
         end
      end
      m_tready = 1'b1;
      beat(6'h2A, 1'b0);
      for (int i = 0; i < 3; i++) beat(6'($urandom), 1'b0);
      step();

      // Test 4: 16 back-to-back beats
      a0 = acc4;
      w0 = words4;
      s_tvalid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         s_tdata = 6'($urandom);
         step();
      end
      s_tvalid = 1'b0;
      check("t4_accepts", 64'(acc4 - a0), 64'(16));
      step();
      check("t4_words", 64'(words4 - w0), 64'(4));

      // Test 5: reset mid-word discards the partial word
      beat(6'h11, 1'b0); beat(6'h22, 1'b0);
      rst = 1'b1;
      step();
      check("t5_rst_tvalid", 64'(m_tvalid), 64'(0));
      check("t5_rst_tdata",  64'(m_tdata),  64'(0));
      check("t5_rst_tuser",  64'(m_tuser),  64'(0));
      check("t5_rst_tlast",  64'(m_tlast),  64'(0));
      rst = 1'b0;
      step();
      check("t5_ready_after_rst", 64'(s_tready), 64'(1));
      beat(6'h0A, 1'b0); beat(6'h0B, 1'b0); beat(6'h0C, 1'b0); beat(6'h0D, 1'b0);
      check("t5_tdata", 64'(m_tdata), 64'(24'h34C2CA));
      check("t5_tuser", 64'(m_tuser), 64'(12));
      step();

      // Random traffic with random back-pressure and tlast on the BEATS=4 instance
      for (int i = 0; i < 300; i++) begin
         s_tvalid = 1'($urandom_range(0, 1));
         s_tdata  = 6'($urandom);
         s_tlast  = ($urandom_range(0, 5) == 0);
         m_tready = ($urandom_range(0, 3) != 0);
         step();
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      beat(6'h00, 1'b1);

      // Test 6: BEATS=1 pass-through with random traffic
      for (int i = 0; i < 300; i++) begin
         s1_tvalid = 1'($urandom_range(0, 1));
         s1_tdata  = 6'($urandom);
         s1_tlast  = 1'($urandom_range(0, 1));
         m1_tready = 1'($urandom_range(0, 1));
         step();
      end
      s1_tvalid = 1'b0;

      // Drain
      m_tready  = 1'b1;
      m1_tready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check("drain_q4_empty", 64'(q4.size()), 64'(0));
      check("drain_q1_empty", 64'(q1.size()), 64'(0));
      check("drain_pend_empty", 64'(pend4.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
